seq_framer_tx: RTL
==================

Name: seq_framer_tx

Overview:
- Serial transmitter for the "111"-framed bit link; the sending end paired with the 111 sequence detector.
- Accepts a parallel word and emits the frame serially, one bit per clk: preamble 1110, then the payload MSB-first.
- Bit-stuffing on the payload guarantees "111" appears on dout only in the preamble. A downstream 111 detector therefore fires exactly once per frame.

Parameters:
- WIDTH, 8: payload width in bits (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  frame request; sampled at the clk edge only while ready=1.
- data  input  WIDTH  payload word; captured at the accepted start edge.
- ready  output  1  1 = idle, start will be accepted.
- dout  output  1  serial output bit; 0 whenever valid=0.
- valid  output  1  1 = dout carries a frame bit this cycle.
- done  output  1  one-cycle pulse in the cycle after the last frame bit.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state=IDLE, ready=1, dout=0, valid=0, done=0, shift register and counters cleared.
- Reset asserted mid-frame: the frame is abandoned immediately, with no partial completion and no done pulse.
- FSM states: IDLE, PRE, PAY, STUFF.
- IDLE:
  - ready=1, valid=0, dout=0.
  - An edge with start=1 loads data into the shift register, clears the preamble index and ones counter, sets ready=0, and moves to PRE.
  - First preamble bit appears on dout in the cycle after the accepting edge (latency 1).
- PRE:
  - Emits 1,1,1,0 on four consecutive cycles with valid=1, then moves to PAY.
  - The trailing 0 prevents a leading payload 1 from extending the 111 run.
- PAY:
  - Emits shreg MSB, then shifts left; bit counter counts WIDTH bits.
  - ones counter (2 bits): increment on an emitted 1, clear on an emitted 0.
  - When an emitted 1 brings the count to 2, the next cycle is STUFF; the counter clears.
  - After the WIDTH-th bit: go to STUFF if a stuff is pending, else end of frame.
- STUFF:
  - Emits one 0 with valid=1.
  - Returns to PAY if payload bits remain, else end of frame.
- End of frame:
  - Next cycle: valid=0, dout=0, done=1 for exactly 1 cycle, ready=1, state=IDLE.
  - start on that same edge is accepted (back-to-back frames, 1 idle cycle between them).
- Frame length = 4 + WIDTH + S, where S = number of stuffed zeros, 0 <= S <= floor(WIDTH/2).
- start while ready=0: ignored; data changes during a frame have no effect.
- The ones counter never counts preamble bits.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, PRE, PAY, STUFF);
  - PREAMBLE = 4'b1110 and PRE_LEN = 4;
  - STUFF_RUN = 2, the run length that triggers a stuff.
- Single module; the shift/stuff logic is too small to justify a sub-module.
- The bench reuses seqDetector111 as a golden checker on dout.

Test Plan:
- data=8'hA5, one start pulse -> dout = 1110 10100101 (12 bits, valid high 12 cycles), no stuffs, done pulse 1 cycle later; detector asserts once.
- data=8'hFF -> dout = 1110 110110110110 (16 bits, S=4), including a stuff after the final bit; done after the 16th bit; detector asserts once.
- data=8'hB6 -> dout = 1110 1011001100 (14 bits, stuffs after payload bits 4 and 7); ready=0 throughout.
- data=8'h00, then start held high continuously -> two back-to-back frames 1110 00000000, separated by exactly 1 idle cycle with valid=0 and done=1.
- start pulsed with data=8'h3C while a frame of 8'hA5 is in flight -> ignored; the A5 frame is unchanged and no extra frame follows.
- reset driven 0 during the 3rd payload bit -> dout, valid and done are 0 immediately (asynchronous) and ready=1; after release, start with 8'hA5 produces a clean 12-bit frame.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the 111-framed serial link: FSM states and framing constants.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PAY   = 2'd2,
    STUFF = 2'd3
  } state_t;

  localparam logic [3:0]  PREAMBLE  = 4'b1110;
  localparam int unsigned PRE_LEN   = 4;
  localparam int unsigned STUFF_RUN = 2;

endpackage

// File: rtl/seq_framer_tx.sv
// Serial framer: emits preamble 1110 then the payload MSB-first, stuffing a 0
// after every run of two payload 1s so that 111 only ever occurs in the preamble.
module seq_framer_tx
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             dout,
  output logic             valid,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       pre_idx;
  logic [1:0]       ones;
  logic             stuff_pend;

  logic       pay_bit;
  logic [1:0] ones_next;
  logic       stuff_hit;
  logic       last_bit;
  logic       pre_last;
  logic [1:0] pre_sel;
  logic       pre_bit;
  logic       do_emit;
  logic       do_end;

  // dout is registered, so each decision below selects the bit shown in the next cycle.
  always_comb begin
    pay_bit   = shreg[WIDTH-1];
    ones_next = pay_bit ? (ones + 2'd1) : 2'd0;
    stuff_hit = (ones_next == 2'(STUFF_RUN));
    last_bit  = (bit_cnt == CNT_W'(WIDTH));
    pre_last  = (pre_idx == 3'(PRE_LEN));
    pre_sel   = 2'(3'(PRE_LEN - 1) - pre_idx);
    pre_bit   = PREAMBLE[pre_sel];
    do_emit   = ((state == PRE) && pre_last)
             || ((state == PAY) && !stuff_pend && !last_bit)
             || ((state == STUFF) && !last_bit);
    do_end    = ((state == PAY) && !stuff_pend && last_bit)
             || ((state == STUFF) && last_bit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      pre_idx    <= '0;
      ones       <= '0;
      stuff_pend <= 1'b0;
      ready      <= 1'b1;
      dout       <= 1'b0;
      valid      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (do_emit) begin
        state      <= PAY;
        dout       <= pay_bit;
        valid      <= 1'b1;
        shreg      <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt    <= bit_cnt + CNT_W'(1);
        ones       <= stuff_hit ? 2'd0 : ones_next;
        stuff_pend <= stuff_hit;
      end else if (do_end) begin
        state <= IDLE;
        dout  <= 1'b0;
        valid <= 1'b0;
        done  <= 1'b1;
        ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            ready <= 1'b1;
            valid <= 1'b0;
            dout  <= 1'b0;
            if (start) begin
              shreg      <= data;
              pre_idx    <= 3'd1;
              ones       <= 2'd0;
              bit_cnt    <= '0;
              stuff_pend <= 1'b0;
              dout       <= PREAMBLE[3];
              valid      <= 1'b1;
              ready      <= 1'b0;
              state      <= PRE;
            end
          end
          PRE: begin
            dout    <= pre_bit;
            pre_idx <= pre_idx + 3'd1;
          end
          PAY: begin
            // Only reached with a stuff pending.
            dout       <= 1'b0;
            stuff_pend <= 1'b0;
            state      <= STUFF;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
